// File: rtl/adc_arb_pkg.sv
// Shared types and defaults for the ADC arbiter.
//   state_e          : arbiter FSM states
//   DW_DEFAULT       : default width of ADC data/length
//   TIMEOUT_DEFAULT  : default cycle budget for REQ / WAIT_LOW
package adc_arb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_LOW = 2'd2
  } state_e;

  localparam int DW_DEFAULT      = 8;
  localparam int TIMEOUT_DEFAULT = 64;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
//   req   : N_REQ request bits
//   ptr   : highest-priority index for this pick
//   valid : any request present
//   idx   : first set request found searching ptr, ptr+1, ... mod N_REQ
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic             valid,
  output logic [IW-1:0]    idx
);

  int k;

  // Walk offsets from farthest to nearest so the closest set bit to ptr
  // is the last (winning) assignment.
  always_comb begin
    valid = |req;
    idx   = '0;
    k     = 0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      k = int'(ptr) + i;
      if (k >= N_REQ) k = k - N_REQ;
      if (req[k]) idx = IW'(k);
    end
  end

endmodule

// File: rtl/adc_arbiter.sv
// Round-robin arbiter sharing one ADC conversion port between N_REQ
// requesters. Runs a 4-phase req/rdy handshake toward the ADC for the
// grantee, registers the returned dat/len and pulses a per-requester
// ready (or error on timeout).
//   clk, rst        : clock, asynchronous active-high reset
//   req_i           : per-requester level requests
//   rdy_o / err_o   : one-cycle completion / abort pulses per requester
//   dat_o / len_o   : last successfully captured ADC result
//   gnt_o           : current or last grantee index
//   busy_o          : FSM not idle
//   adc_req         : request toward ADC
//   adc_rdy/dat/len : ADC acknowledge and result
module adc_arbiter
  import adc_arb_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int DW      = DW_DEFAULT,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_i,
  output logic [N_REQ-1:0]         rdy_o,
  output logic [N_REQ-1:0]         err_o,
  output logic [DW-1:0]            dat_o,
  output logic [DW-1:0]            len_o,
  output logic [$clog2(N_REQ)-1:0] gnt_o,
  output logic                     busy_o,
  output logic                     adc_req,
  input  logic                     adc_rdy,
  input  logic [DW-1:0]            adc_dat,
  input  logic [DW-1:0]            adc_len
);

  localparam int GW = $clog2(N_REQ);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TCNT_LAST = TW'(TIMEOUT - 1);
  localparam logic [GW-1:0] GNT_LAST  = GW'(N_REQ - 1);

  state_e            state_q, state_d;
  logic [GW-1:0]     ptr_q, ptr_d;
  logic [GW-1:0]     gnt_q, gnt_d;
  logic [TW-1:0]     tcnt_q, tcnt_d;
  logic              adc_req_q, adc_req_d;
  logic              busy_q, busy_d;
  logic [N_REQ-1:0]  rdy_q, rdy_d;
  logic [N_REQ-1:0]  err_q, err_d;
  logic [DW-1:0]     dat_q, dat_d;
  logic [DW-1:0]     len_q, len_d;

  logic              arb_valid;
  logic [GW-1:0]     arb_idx;
  logic [GW-1:0]     gnt_next;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IW    (GW)
  ) u_rr (
    .req   (req_i),
    .ptr   (ptr_q),
    .valid (arb_valid),
    .idx   (arb_idx)
  );

  // Pointer moves just past the grantee so it becomes lowest priority.
  assign gnt_next = (gnt_q == GNT_LAST) ? '0 : gnt_q + GW'(1);

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_d     = gnt_q;
    tcnt_d    = tcnt_q;
    adc_req_d = adc_req_q;
    rdy_d     = '0;
    err_d     = '0;
    dat_d     = dat_q;
    len_d     = len_q;

    case (state_q)
      IDLE: begin
        if (arb_valid) begin
          gnt_d     = arb_idx;
          adc_req_d = 1'b1;
          tcnt_d    = '0;
          state_d   = REQ;
        end
      end
      REQ: begin
        // adc_rdy takes precedence over an expiring timeout.
        if (adc_rdy) begin
          dat_d         = adc_dat;
          len_d         = adc_len;
          rdy_d[gnt_q]  = 1'b1;
          adc_req_d     = 1'b0;
          ptr_d         = gnt_next;
          tcnt_d        = '0;
          state_d       = WAIT_LOW;
        end else if (tcnt_q == TCNT_LAST) begin
          err_d[gnt_q]  = 1'b1;
          adc_req_d     = 1'b0;
          ptr_d         = gnt_next;
          tcnt_d        = '0;
          state_d       = WAIT_LOW;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      WAIT_LOW: begin
        // A stuck-high ADC is abandoned silently once the budget runs out.
        if (!adc_rdy || tcnt_q == TCNT_LAST) begin
          state_d = IDLE;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      default: begin
        state_d   = IDLE;
        adc_req_d = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      gnt_q     <= '0;
      tcnt_q    <= '0;
      adc_req_q <= 1'b0;
      busy_q    <= 1'b0;
      rdy_q     <= '0;
      err_q     <= '0;
      dat_q     <= '0;
      len_q     <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      tcnt_q    <= tcnt_d;
      adc_req_q <= adc_req_d;
      busy_q    <= busy_d;
      rdy_q     <= rdy_d;
      err_q     <= err_d;
      dat_q     <= dat_d;
      len_q     <= len_d;
    end
  end

  assign rdy_o   = rdy_q;
  assign err_o   = err_q;
  assign dat_o   = dat_q;
  assign len_o   = len_q;
  assign gnt_o   = gnt_q;
  assign busy_o  = busy_q;
  assign adc_req = adc_req_q;

endmodule

// File: tb/tb_adc_arbiter.sv
module tb_adc_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req_i;
  logic [3:0] rdy_o;
  logic [3:0] err_o;
  logic [7:0] dat_o;
  logic [7:0] len_o;
  logic [1:0] gnt_o;
  logic       busy_o;
  logic       adc_req;
  logic       adc_rdy;
  logic [7:0] adc_dat;
  logic [7:0] adc_len;

  adc_arbiter #(.N_REQ(4), .DW(8), .TIMEOUT(64)) dut (
    .clk     (clk),
    .rst     (rst),
    .req_i   (req_i),
    .rdy_o   (rdy_o),
    .err_o   (err_o),
    .dat_o   (dat_o),
    .len_o   (len_o),
    .gnt_o   (gnt_o),
    .busy_o  (busy_o),
    .adc_req (adc_req),
    .adc_rdy (adc_rdy),
    .adc_dat (adc_dat),
    .adc_len (adc_len)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [3:0] rdy;
    logic [3:0] err;
    logic [7:0] dat;
    logic [7:0] len;
    logic [1:0] gnt;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] rsp_q[$];
  exp_t        mon_e;
  logic [7:0]  last_dat;
  logic [7:0]  last_len;
  int          checks;
  int          errors;
  int          adc_mode;   // 0 normal, 1 never answers, 2 answers then sticks high
  int          adc_delay;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic expect_ok(input logic [3:0] oh, input logic [1:0] g,
                           input logic [7:0] d, input logic [7:0] l);
    exp_t e;
    e = '{rdy: oh, err: 4'b0000, dat: d, len: l, gnt: g};
    exp_q.push_back(e);
    rsp_q.push_back({d, l});
    last_dat = d;
    last_len = l;
  endtask

  task automatic expect_err(input logic [3:0] oh, input logic [1:0] g);
    exp_t e;
    e = '{rdy: 4'b0000, err: oh, dat: last_dat, len: last_len, gnt: g};
    exp_q.push_back(e);
  endtask

  // ADC model: answers adc_delay cycles after seeing adc_req.
  initial begin
    int wcnt;
    logic [15:0] r;
    adc_rdy = 1'b0;
    adc_dat = 8'h00;
    adc_len = 8'h00;
    wcnt    = 0;
    forever begin
      @(posedge clk);
      #1;
      if (adc_mode == 1) begin
        adc_rdy = 1'b0;
        wcnt    = 0;
      end else if (!adc_req) begin
        wcnt = 0;
        if (adc_mode == 0) adc_rdy = 1'b0;
      end else if (!adc_rdy) begin
        wcnt++;
        if (wcnt >= adc_delay) begin
          r = (rsp_q.size() > 0) ? rsp_q.pop_front() : 16'hEEEE;
          adc_dat = r[15:8];
          adc_len = r[7:0];
          adc_rdy = 1'b1;
        end
      end
    end
  end

  // Scoreboard monitor.
  initial begin
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && (rdy_o | err_o) != 4'b0000) begin
        chk("pulse_onehot", 32'($countones(rdy_o | err_o)), 32'd1);
        if (exp_q.size() == 0) begin
          chk("unexpected_pulse", 32'({rdy_o, err_o}), 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("sb_rdy", 32'(rdy_o), 32'(mon_e.rdy));
          chk("sb_err", 32'(err_o), 32'(mon_e.err));
          chk("sb_dat", 32'(dat_o), 32'(mon_e.dat));
          chk("sb_len", 32'(len_o), 32'(mon_e.len));
          chk("sb_gnt", 32'(gnt_o), 32'(mon_e.gnt));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic run_until(input int n, input int maxc, input bit drop, input string nm);
    int got;
    got = 0;
    for (int c = 0; c < maxc; c++) begin
      @(negedge clk);
      if ((rdy_o | err_o) != 4'b0000) begin
        got++;
        if (drop) req_i = req_i & ~(rdy_o | err_o);
        if (got == n) return;
      end
    end
    chk({nm, "_pulse_timeout"}, 32'(got), 32'(n));
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while (busy_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_idle"}, 32'(busy_o), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    last_dat = 8'h00;
    last_len = 8'h00;
  endtask

  initial begin
    int cnt;
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    req_i     = 4'b0000;
    adc_mode  = 0;
    adc_delay = 2;
    last_dat  = 8'h00;
    last_len  = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_adc_req", 32'(adc_req), 32'd0);
    chk("rst_rdy",     32'(rdy_o),   32'd0);
    chk("rst_err",     32'(err_o),   32'd0);
    chk("rst_dat",     32'(dat_o),   32'd0);
    chk("rst_len",     32'(len_o),   32'd0);
    chk("rst_gnt",     32'(gnt_o),   32'd0);
    chk("rst_busy",    32'(busy_o),  32'd0);
    rst = 1'b0;

    // Single request
    @(negedge clk);
    expect_ok(4'b0001, 2'd0, 8'hA5, 8'h10);
    req_i = 4'b0001;
    @(negedge clk);
    chk("single_adc_req_lat", 32'(adc_req), 32'd1);
    chk("single_gnt",         32'(gnt_o),   32'd0);
    chk("single_busy",        32'(busy_o),  32'd1);
    run_until(1, 20, 1'b1, "single");
    chk("single_dat", 32'(dat_o), 32'hA5);
    chk("single_len", 32'(len_o), 32'h10);
    @(negedge clk);
    chk("single_rdy_one_cycle", 32'(rdy_o), 32'd0);
    wait_idle("single");

    // Fairness
    do_reset();
    adc_delay = 1;
    expect_ok(4'b0001, 2'd0, 8'h11, 8'h01);
    expect_ok(4'b0010, 2'd1, 8'h22, 8'h02);
    expect_ok(4'b0100, 2'd2, 8'h33, 8'h03);
    expect_ok(4'b1000, 2'd3, 8'h44, 8'h04);
    expect_ok(4'b0001, 2'd0, 8'h55, 8'h05);
    req_i = 4'b1111;
    run_until(5, 100, 1'b0, "fair");
    req_i = 4'b0000;
    wait_idle("fair");

    // Timeout in REQ
    adc_mode = 1;
    expect_err(4'b0100, 2'd2);
    req_i = 4'b0100;
    cnt = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (err_o != 4'b0000) break;
      if (adc_req) cnt++;
    end
    req_i = 4'b0000;
    chk("timeout_req_cycles", 32'(cnt),     32'd64);
    chk("timeout_adc_req",    32'(adc_req), 32'd0);
    chk("timeout_dat_kept",   32'(dat_o),   32'h55);
    wait_idle("timeout");
    adc_mode  = 0;
    adc_delay = 2;
    expect_ok(4'b0001, 2'd0, 8'h3C, 8'h04);
    req_i = 4'b0001;
    run_until(1, 20, 1'b1, "after_timeout");
    wait_idle("after_timeout");

    // Stuck-high ADC
    adc_mode = 2;
    expect_ok(4'b0010, 2'd1, 8'h77, 8'h08);
    req_i = 4'b0010;
    run_until(1, 20, 1'b1, "stuck");
    cnt = 0;
    while (busy_o && cnt < 200) begin
      cnt++;
      @(negedge clk);
    end
    chk("stuck_busy_cycles", 32'(cnt), 32'd64);
    adc_mode = 0;
    repeat (2) @(negedge clk);
    expect_ok(4'b1000, 2'd3, 8'h99, 8'h0C);
    req_i = 4'b1000;
    run_until(1, 20, 1'b1, "after_stuck");
    wait_idle("after_stuck");

    // Reset in the middle of REQ
    adc_mode = 1;
    req_i = 4'b0100;
    cnt = 0;
    while (!adc_req && cnt < 10) begin
      @(negedge clk);
      cnt++;
    end
    chk("midrst_req_seen", 32'(adc_req), 32'd1);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2;
    rst   = 1'b1;
    req_i = 4'b0000;
    #1;
    chk("midrst_adc_req_async", 32'(adc_req), 32'd0);
    chk("midrst_busy",          32'(busy_o),  32'd0);
    chk("midrst_no_pulse",      32'(rdy_o | err_o), 32'd0);
    @(negedge clk);
    last_dat = 8'h00;
    last_len = 8'h00;
    rst      = 1'b0;
    adc_mode = 0;
    @(negedge clk);
    expect_ok(4'b0010, 2'd1, 8'h5A, 8'h01);
    expect_ok(4'b1000, 2'd3, 8'h6B, 8'h02);
    req_i = 4'b1010;
    run_until(2, 40, 1'b1, "rr_after_reset");
    wait_idle("rr_after_reset");

    // Simultaneous arrival while requester 0 in service
    adc_delay = 3;
    expect_ok(4'b0001, 2'd0, 8'h81, 8'h21);
    expect_ok(4'b0010, 2'd1, 8'h82, 8'h22);
    expect_ok(4'b0001, 2'd0, 8'h83, 8'h23);
    req_i = 4'b0001;
    @(negedge clk);
    chk("sim_first_adc_req", 32'(adc_req), 32'd1);
    req_i = 4'b0011;
    run_until(1, 20, 1'b1, "sim_first");
    @(negedge clk);
    req_i = req_i | 4'b0001;
    @(negedge clk);
    chk("sim_spacing_adc_req", 32'(adc_req), 32'd1);
    chk("sim_spacing_gnt",     32'(gnt_o),   32'd1);
    run_until(2, 40, 1'b1, "sim_rest");
    wait_idle("sim");

    repeat (2) @(negedge clk);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/adc_arbiter.md
Name: adc_arbiter

Overview:
Shares one ADC conversion port between N_REQ frame-builder requesters (SF-class blocks) using round-robin arbitration.
- Runs a 4-phase req/rdy handshake toward the ADC on behalf of the granted requester.
- Captures the returned dat/len into registers and pulses a per-requester ready.
- Guards against a dead ADC with a timeout.
- Sits between the SF instances and the single ADC in the acquisition path.

Parameters:
N_REQ, 4, number of requesters (2..8)
DW, 8, width of dat and len
TIMEOUT, 64, max cycles spent in REQ or WAIT_LOW before abort (>=4)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
req_i  in  N_REQ  per-requester level request; requester holds it until its rdy_o or err_o pulse
rdy_o  out  N_REQ  one-cycle pulse: conversion result for that requester valid on dat_o/len_o
err_o  out  N_REQ  one-cycle pulse: that requester's conversion aborted by timeout
dat_o  out  DW  registered result data, shared by all requesters
len_o  out  DW  registered result length, shared by all requesters
gnt_o  out  $clog2(N_REQ)  index of current/last grantee
busy_o  out  1  high whenever state != IDLE
adc_req  out  1  request to ADC
adc_rdy  in  1  ADC ready/ack
adc_dat  in  DW  ADC data, valid while adc_rdy=1
adc_len  in  DW  ADC length, valid while adc_rdy=1

Behaviour:
Reset values:
- adc_req=0, rdy_o=0, err_o=0, dat_o=0, len_o=0, gnt_o=0, busy_o=0.
- State IDLE, round-robin pointer ptr=0, timeout counter tcnt=0.
- Reset mid-transaction drops adc_req immediately (asynchronous) and discards the transaction; no rdy_o/err_o pulse.

States: IDLE, REQ, WAIT_LOW. All outputs are registered.

IDLE:
- If any req_i bit is set, grant the first set bit searching ptr, ptr+1, ... modulo N_REQ.
- Next cycle: gnt_o=grant, adc_req=1, tcnt=0, state REQ.
- If no req_i bit is set, stay in IDLE.
- Requests arriving in any other state wait; they are not lost while held high.

REQ:
- adc_rdy=1 sampled: register adc_dat/adc_len into dat_o/len_o; next cycle rdy_o[gnt]=1 for exactly one cycle; adc_req=0; ptr=gnt+1 mod N_REQ; tcnt=0; state WAIT_LOW.
- Otherwise tcnt++.
- tcnt==TIMEOUT-1 without adc_rdy: next cycle err_o[gnt]=1 for one cycle; adc_req=0; dat_o/len_o unchanged; ptr=gnt+1; tcnt=0; state WAIT_LOW.

WAIT_LOW:
- adc_rdy=0 sampled: state IDLE.
- Otherwise tcnt++; at tcnt==TIMEOUT-1 force state IDLE with no pulse (ADC stuck high).

Latency:
- req_i rising to adc_req high: 1 cycle.
- adc_rdy sampled high to rdy_o pulse: 1 cycle.
- Minimum back-to-back grant spacing: 3 cycles (REQ → WAIT_LOW → IDLE → REQ).

Simultaneous events:
- Multiple req_i in IDLE: round-robin decides.
- adc_rdy and timeout in the same cycle: adc_rdy wins, giving a normal completion.

Requester side:
- A requester that deasserts req_i after grant does not cancel the transaction; it still receives rdy_o.
- A requester still holding req_i after its pulse is treated as a new request at the lowest priority.

Invariants:
- At most one bit of rdy_o|err_o is set in any cycle.
- Stale dat_o/len_o persist until the next successful capture.

Decomposition:
- Package adc_arb_pkg holds the state enum (IDLE, REQ, WAIT_LOW) and default constants for DW and TIMEOUT.
- One sub-module, rr_arbiter: combinational N_REQ-wide round-robin picker with inputs req and ptr, outputs valid and idx.
- FSM, timeout counter and result registers stay in adc_arbiter.

Test Plan:
- Single request: req_i=0001, ADC model answers adc_rdy 2 cycles after adc_req with dat=0xA5, len=0x10 → adc_req rises 1 cycle after req_i; rdy_o=0001 for one cycle; dat_o=0xA5, len_o=0x10; gnt_o=0.
- Fairness: req_i=1111 held, ADC always answers → grants come in the order 0,1,2,3,0; each rdy_o bit pulses once per round; no more than one bit high per cycle.
- Timeout: req_i=0100, ADC never asserts adc_rdy → after TIMEOUT=64 cycles in REQ, err_o=0100 pulses once; adc_req=0; dat_o unchanged; next request is granted normally.
- Stuck-high ADC: adc_rdy held 1 after a completion → FSM leaves WAIT_LOW after 64 cycles; busy_o drops; the next grant proceeds.
- Reset mid-REQ: assert rst while adc_req=1 → adc_req=0 asynchronously; no rdy_o/err_o; after release ptr=0, so req_i=1010 grants requester 1 first.
- Simultaneous arrival: req_i goes 0001→0011 while requester 0 is in service → requester 1 is granted immediately after requester 0 completes; requester 0 re-raising req_i waits behind requester 1.
